// File: rtl/ddr3_frame_reader.sv
// ddr3_frame_reader
//
// Avalon-MM burst-read master. It fetches a frame buffer from the DDR3
// controller and presents it as a valid/ready word stream for the VGA pixel
// pipeline. Read data lands in an internal first-word-fall-through FIFO. A
// burst is only issued when the FIFO has room for the whole burst, counting
// the words that are already in flight.
//
// Build option:
//   FRAME_READER_LOOP_EN  When defined, the reader re-latches frame_base and
//                         frame_words from the ports as the last burst of a
//                         frame is accepted, and starts the next frame
//                         straight away. done pulses once per frame, and busy
//                         stays high until reset. When undefined, each start
//                         pulse reads one frame.
//
// Ports:
//   clk, reset_n        fabric clock; asynchronous active-low reset
//   start               1-cycle pulse; latches frame_base/frame_words in IDLE
//   frame_base          byte address of word 0 (DATA_W/8 aligned)
//   frame_words         frame length in DATA_W words
//   busy, done          frame in progress / 1-cycle pulse after last word
//                       is accepted on pix
//   avm_*               Avalon-MM burst read master
//   pix_data/valid/ready  output word stream (head of FIFO)
//
// State | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start
// ISSUE | burst = min(BURST_LEN, words_left); wait for FIFO room
// REQ   | avm_read held with stable address/burstcount until accepted
// DRAIN | all bursts accepted; wait for the frame's last word to be popped

module ddr3_frame_reader #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int BURST_LEN  = 16,
    parameter int BURST_W    = 5,
    parameter int FIFO_DEPTH = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] frame_base,
    input  logic [23:0]       frame_words,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic [BURST_W-1:0] avm_burstcount,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready
);

    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int BYTE_SHIFT = $clog2(DATA_W / 8);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_REQ   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [23:0]       words_left;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  fifo_count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Each FIFO entry carries an end-of-frame tag next to the data word so
    // done can be raised exactly when the frame's final word leaves, even
    // when several frames are in the FIFO at once.
    logic [DATA_W:0]   fifo_mem [FIFO_DEPTH];

    // One descriptor per accepted burst (length + last-of-frame flag),
    // consumed in order as the read data returns. Every burst holds at least
    // one word and in-flight words never exceed FIFO_DEPTH, so FIFO_DEPTH
    // descriptors are always enough.
    logic [BURST_W-1:0]    desc_len [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] desc_last;
    logic [PTR_W-1:0]      desc_wr_ptr;
    logic [PTR_W-1:0]      desc_rd_ptr;
    logic [BURST_W-1:0]    rx_cnt;

    logic [BURST_W-1:0] burst_c;
    logic [31:0]        free_c;
    logic               can_issue;
    logic               accept;
    logic               last_burst;
    logic               push;
    logic               pop;
    logic               head_last;
    logic               rx_last_of_burst;
    logic               push_last;
    logic [ADDR_W-1:0]  addr_step;
    logic [DATA_W:0]    head;

    always_comb begin
        burst_c = words_left[BURST_W-1:0];
        if (words_left >= 24'(BURST_LEN)) begin
            burst_c = BURST_W'(BURST_LEN);
        end
    end

    // fifo_count + outstanding is only lowered by pops, because a returning
    // word moves from one term to the other. The registered sum is therefore
    // never optimistic.
    assign free_c    = 32'(FIFO_DEPTH) - 32'(fifo_count) - 32'(outstanding);
    assign can_issue = free_c >= 32'(burst_c);

    assign accept     = (state == S_REQ) && !avm_waitrequest;
    assign last_burst = (words_left == 24'(avm_burstcount));
    assign addr_step  = ADDR_W'(avm_burstcount) << BYTE_SHIFT;

    // Data arriving with nothing outstanding is stale, for example from
    // before a reset, so it is dropped.
    assign push = avm_readdatavalid && (outstanding != '0);

    assign rx_last_of_burst = (rx_cnt == desc_len[desc_rd_ptr] - BURST_W'(1));
    assign push_last        = desc_last[desc_rd_ptr] && rx_last_of_burst;

    assign head      = fifo_mem[rd_ptr];
    assign pix_data  = head[DATA_W-1:0];
    assign head_last = head[DATA_W];
    assign pix_valid = (fifo_count != '0);
    assign pop       = pix_valid && pix_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {push_last, avm_readdata};
        end
        if (accept) begin
            desc_len[desc_wr_ptr]  <= avm_burstcount;
            desc_last[desc_wr_ptr] <= last_burst;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            desc_wr_ptr <= '0;
            desc_rd_ptr <= '0;
            rx_cnt      <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (rx_last_of_burst) begin
                    rx_cnt      <= '0;
                    desc_rd_ptr <= desc_rd_ptr + PTR_W'(1);
                end else begin
                    rx_cnt <= rx_cnt + BURST_W'(1);
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (accept) begin
                desc_wr_ptr <= desc_wr_ptr + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase

            case ({accept, push})
                2'b10:   outstanding <= outstanding + CNT_W'(avm_burstcount);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                2'b11:   outstanding <= outstanding + CNT_W'(avm_burstcount) - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            avm_read       <= 1'b0;
            avm_address    <= '0;
            avm_burstcount <= '0;
            cur_addr       <= '0;
            words_left     <= '0;
        end else begin
            done <= pop && head_last;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (frame_words == '0) begin
                            done <= 1'b1;
                        end else begin
                            cur_addr   <= frame_base;
                            words_left <= frame_words;
                            busy       <= 1'b1;
                            state      <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    if ((words_left != '0) && can_issue) begin
                        avm_read       <= 1'b1;
                        avm_address    <= cur_addr;
                        avm_burstcount <= burst_c;
                        state          <= S_REQ;
                    end
`ifdef FRAME_READER_LOOP_EN
                    // An empty frame on the live ports: keep polling them.
                    if (words_left == '0) begin
                        cur_addr   <= frame_base;
                        words_left <= frame_words;
                    end
`endif
                end

                S_REQ: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        if (last_burst) begin
`ifdef FRAME_READER_LOOP_EN
                            cur_addr   <= frame_base;
                            words_left <= frame_words;
                            state      <= S_ISSUE;
`else
                            cur_addr   <= cur_addr + addr_step;
                            words_left <= '0;
                            state      <= S_DRAIN;
`endif
                        end else begin
                            cur_addr   <= cur_addr + addr_step;
                            words_left <= words_left - 24'(avm_burstcount);
                            state      <= S_ISSUE;
                        end
                    end
                end

                S_DRAIN: begin
                    if (pop && head_last) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
